// File: rtl/spi_cmd_pkg.sv
// Shared widths, defaults and unpacker state encoding for the SPI command writer.
// No logic, no latency.
// No flow control.
package spi_cmd_pkg;

    localparam int CMD_W              = 16;
    localparam int HOST_W             = 32;
    localparam int DEFAULT_FIFO_DEPTH = 512;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LO    = 2'd1,
        HI    = 2'd2
    } unp_state_e;

endpackage

// File: rtl/spi_cmd_sync_fifo.sv
// Single-clock FIFO whose head sits in a registered output stage (the prefetch word).
// Latency: a push into an empty FIFO is visible on rd_vld_o after the next edge.
// Backpressure: full_o from the registered level; level_o also counts the output-stage word.
module spi_cmd_sync_fifo #(
    parameter int DEPTH = 512,
    parameter int DW    = 32,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [DW-1:0]    wr_dat_i,
    input  logic             rd_en_i,
    output logic             rd_vld_o,
    output logic [DW-1:0]    rd_dat_o,
    output logic [LVL_W-1:0] level_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, mem_cnt;
    logic             ov_q;
    logic [DW-1:0]    rd_dat_q;
    logic             push, pop, load;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign mem_cnt = level_q - LVL_W'(ov_q);
    assign push    = wr_en_i && !full_o;
    assign pop     = rd_en_i && ov_q;
    // Refill the output stage in the same cycle it is consumed to keep streaming bubble-free.
    assign load    = (mem_cnt != '0) && (!ov_q || pop);

    always_ff @(posedge clk) begin
        if (push && !flush_i) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ov_q     <= 1'b0;
            rd_dat_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ov_q     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (load) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                rd_dat_q <= mem_q[rd_ptr_q];
                ov_q     <= 1'b1;
            end else if (pop) begin
                ov_q     <= 1'b0;
            end
            level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
        end
    end

    assign rd_vld_o = ov_q;
    assign rd_dat_o = rd_dat_q;
    assign level_o  = level_q;

endmodule

// File: rtl/spi_xillybus_cmd_writer.sv
// Xillybus 32-bit write pipe to 16-bit SPI command stream, low half first; SPI_CMD_ZERO_SKIP_EN drops 0x0000 halves.
// Latency: word written at edge N is presented (low half) after edge N+2; one command per cycle when streaming.
// Backpressure: valid/ready on cmd side, user_w_spi_cmd_32_full toward the host; open low flushes.
module spi_xillybus_cmd_writer
    import spi_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              bus_clk,
    input  logic              reset_n,
    input  logic              user_w_spi_cmd_32_open,
    input  logic              user_w_spi_cmd_32_wren,
    input  logic [HOST_W-1:0] user_w_spi_cmd_32_data,
    output logic              user_w_spi_cmd_32_full,
    output logic [CMD_W-1:0]  cmd_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [LVL_W-1:0]  cmd_fifo_level,
    output logic              cmd_overrun,
    output logic [CMD_W-1:0]  cmd_count
);
    unp_state_e        state_q, state_d;
    logic [HOST_W-1:0] cur_q, cur_d;
    logic              overrun_q, overrun_d;
    logic [CMD_W-1:0]  count_q;
    logic              flush, fifo_vld, pop, hs, zero_half, advance;
    logic [HOST_W-1:0] fifo_dat;
    logic [CMD_W-1:0]  half;

    assign flush = !user_w_spi_cmd_32_open;

    spi_cmd_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (HOST_W),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk      (bus_clk),
        .rst_n    (reset_n),
        .flush_i  (flush),
        .wr_en_i  (user_w_spi_cmd_32_wren && user_w_spi_cmd_32_open),
        .wr_dat_i (user_w_spi_cmd_32_data),
        .rd_en_i  (pop),
        .rd_vld_o (fifo_vld),
        .rd_dat_o (fifo_dat),
        .level_o  (cmd_fifo_level),
        .full_o   (user_w_spi_cmd_32_full)
    );

    assign half = (state_q == HI) ? cur_q[HOST_W-1:CMD_W] : cur_q[CMD_W-1:0];

`ifdef SPI_CMD_ZERO_SKIP_EN
    assign zero_half = (state_q != EMPTY) && (half == '0);
`else
    assign zero_half = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        pop       = 1'b0;
        cmd_valid = (state_q != EMPTY) && !zero_half;
        hs        = cmd_valid && cmd_ready;
        advance   = hs || zero_half;
        case (state_q)
            EMPTY: begin
                if (fifo_vld) begin
                    pop     = 1'b1;
                    cur_d   = fifo_dat;
                    state_d = LO;
                end
            end
            LO: begin
                if (advance) begin
                    state_d = HI;
                end
            end
            HI: begin
                if (advance) begin
                    if (fifo_vld) begin
                        pop     = 1'b1;
                        cur_d   = fifo_dat;
                        state_d = LO;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
            pop     = 1'b0;
        end
    end

    always_comb begin
        overrun_d = overrun_q;
        if (flush) begin
            overrun_d = 1'b0;
        end else if (user_w_spi_cmd_32_wren && user_w_spi_cmd_32_full) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge bus_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= EMPTY;
            cur_q     <= '0;
            overrun_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            overrun_q <= overrun_d;
            count_q   <= count_q + CMD_W'(hs);
        end
    end

    assign cmd_data    = cmd_valid ? half : '0;
    assign cmd_overrun = overrun_q;
    assign cmd_count   = count_q;

endmodule

// File: doc/spi_xillybus_cmd_writer.md
# spi_xillybus_cmd_writer

Host-to-FPGA command path for the SPI acquisition front end. Accepts 32-bit words from the Xillybus write pipe `user_w_spi_cmd_32`, buffers them in a single-clock FIFO, and unpacks each word into two 16-bit SPI command words. Low half goes first, then high half, matching the 16-bit host word order of the neural data read pipe. Commands go out on a valid/ready stream to the SPI command sequencer, entirely in the `bus_clk` domain.

## Interface
Parameters:
- `FIFO_DEPTH`, 512: 32-bit entries, power of two, ≥4.
- `LVL_W`, $clog2(FIFO_DEPTH)+1: width of the level output.

Ports:
- `bus_clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `user_w_spi_cmd_32_open`  in  1  host pipe open; low flushes the block.
- `user_w_spi_cmd_32_wren`  in  1  host write strobe.
- `user_w_spi_cmd_32_data`  in  32  host word.
- `user_w_spi_cmd_32_full`  out  1  FIFO full; Xillybus back-pressure.
- `cmd_data`  out  16  command word.
- `cmd_valid`  out  1  `cmd_data` valid.
- `cmd_ready`  in  1  sequencer accepts.
- `cmd_fifo_level`  out  LVL_W  FIFO occupancy in 32-bit entries.
- `cmd_overrun`  out  1  sticky: a write was dropped.
- `cmd_count`  out  16  commands delivered, wraps at 0xFFFF→0.

## Operation
- **Write side:** the FIFO stores `data` when `wren && !full && open`. A `wren` while `full` is dropped and sets `cmd_overrun`.
- **Full flag:** `full` is `level==FIFO_DEPTH`, based on the registered level. A same-cycle pop does not admit a write at full.
- **Unpacker:** holds a current word and one prefetch word. Prefetch loads whenever it is empty and the FIFO is non-empty.
- **Unpacker states:**
  - EMPTY→LO when a word is available.
  - LO presents `[15:0]`; on handshake (`cmd_valid && cmd_ready`) it goes to HI.
  - HI presents `[31:16]`; on handshake it goes to LO if the prefetch is valid, otherwise EMPTY.
- **Output stability:** `cmd_data` is stable while `cmd_valid && !cmd_ready`, and `cmd_valid` never drops without a handshake, except on flush.
- **cmd_count:** increments once per handshake.
- **Flush:** `open==0` applies a synchronous flush every cycle it is held:
  - FIFO, prefetch, state→EMPTY, `cmd_valid`=0, `cmd_overrun`=0.
  - `cmd_count` is kept; it clears only on `reset_n`.
- **Reset values:** `full` 0, `cmd_valid` 0, `cmd_data` 0, `cmd_fifo_level` 0, `cmd_overrun` 0, `cmd_count` 0, state EMPTY.
- **Reset mid-transfer:** discards all buffered commands. No partial command is ever output after reset.

## Timing
- **Latency:** a word written at edge N into an empty block gives `cmd_valid`=1 after edge N+2, presenting the low half.
- **Throughput:** with the FIFO non-empty and `cmd_ready` held high, one command per cycle with no bubble between words.
- **Level:** `cmd_fifo_level` updates at the edge after a push/pop. A simultaneous push and pop leaves the level unchanged.
- **Flush timing:** `open` falling at edge N gives `cmd_valid`=0 and level 0 after edge N+1.
- **Reopen:** writes are accepted from the first cycle `open`=1.

## Configuration
- Macro `SPI_CMD_ZERO_SKIP_EN`.
- **Defined:** a 16-bit half equal to 0x0000 is skipped without asserting `cmd_valid`. Each skip costs one cycle in that state, is not counted, and lets the host pad odd-length command lists.
- **Undefined:** 0x0000 is delivered as an ordinary command.

## Structure
- **Package `spi_cmd_pkg`:**
  - `CMD_W`=16
  - `HOST_W`=32
  - `DEFAULT_FIFO_DEPTH`=512
  - unpacker state enum {EMPTY, LO, HI}
- **Sub-module `spi_cmd_sync_fifo`:**
  - single-clock, registered-read FIFO with level output and synchronous flush port.
  - The unpacker and counters stay in the top.

## Test plan
- **Single word:** write 0xBEEF1234 with ready=1 → 0x1234 then 0xBEEF on consecutive cycles, first valid 2 cycles after `wren`, `cmd_count`=2.
- **Back-pressure:**
  - stimulus: ready=0, write 4 words.
  - response: `cmd_data`=low half of word 0 held stable, level=3 (one word in prefetch); releasing ready streams 8 commands with no bubble.
- **Overflow:**
  - stimulus: ready=0, write FIFO_DEPTH+2 words.
  - response: `full`=1 once level=FIFO_DEPTH, extra write dropped, `cmd_overrun`=1; drained data matches the first accepted words only.
- **Close mid-stream:**
  - stimulus: 10 words queued, `open`→0 for 1 cycle.
  - response: valid=0, level=0, overrun=0, `cmd_count` unchanged; reopen and write 0x00020001 → 0x0001, 0x0002.
- **Async reset:** assert `reset_n`=0 mid-HI state → all outputs at reset values immediately; no stale command after release.
- **Zero skip:**
  - stimulus: write 0x00000000 and 0x0000ABCD.
  - with `SPI_CMD_ZERO_SKIP_EN`: only 0xABCD delivered, count=1.
  - without the macro: 0x0000, 0x0000, 0xABCD, 0x0000 delivered, count=4.
